// File: rtl/mem_if.sv
// Bus between a core and mem_unit: instruction fetch, data access handshake,
// and an instruction-memory load port.
interface mem_if;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   // Program-load port: writes one aligned word into instruction memory
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;

   modport master (
      output pc, req, we, funct3, addr, wdata, im_we, im_addr, im_wdata,
      input  instr, ready, done, err, rdata
   );

   modport slave (
      input  pc, req, we, funct3, addr, wdata, im_we, im_addr, im_wdata,
      output instr, ready, done, err, rdata
   );
endinterface

// File: rtl/mem_unit.sv
// Instruction ROM-style fetch plus a wait-stated RV32I data memory controller
// with byte/half/word lanes, sign/zero extension and alignment/range faults.
module mem_unit #(
   parameter int unsigned IM_DEPTH    = 64,
   parameter int unsigned DM_DEPTH    = 64,
   parameter int unsigned WAIT_STATES = 2
) (
   input logic   clk,
   input logic   rst,
   mem_if.slave  bus
);

   localparam int unsigned IM_AW = $clog2(IM_DEPTH);
   localparam int unsigned DM_AW = $clog2(DM_DEPTH);
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   logic [31:0] im [IM_DEPTH];
   logic [31:0] dm [DM_DEPTH];

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q;
   logic        fault_q, fault_d;
   logic [31:0] rdata_q, rdata_d;
   logic        accept, enter_resp;

   // ---------------- instruction side ----------------
   logic              pc_ok, im_wr_ok;
   logic [IM_AW-1:0]  pc_idx, im_wr_idx;

   always_comb begin
      pc_ok     = (bus.pc[1:0] == 2'b00) && ((bus.pc >> (IM_AW + 2)) == 32'd0);
      pc_idx    = bus.pc[IM_AW+1:2];
      im_wr_ok  = bus.im_we && (bus.im_addr[1:0] == 2'b00)
                  && ((bus.im_addr >> (IM_AW + 2)) == 32'd0);
      im_wr_idx = bus.im_addr[IM_AW+1:2];
      bus.instr = pc_ok ? im[pc_idx] : NOP;
   end

   always_ff @(posedge clk) begin
      if (im_wr_ok) begin
         im[im_wr_idx] <= bus.im_wdata;
      end
   end

   // ---------------- data side ----------------
   function automatic logic calc_fault(input logic w, input logic [2:0] f3,
                                       input logic [31:0] a);
      logic f;
      f = ((a >> (DM_AW + 2)) != 32'd0);
      case (f3)
         3'b000:  f = f;
         3'b001:  f = f | a[0];
         3'b010:  f = f | (a[1:0] != 2'b00);
         3'b100:  f = f | w;
         3'b101:  f = f | w | a[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

   // In IDLE the access is taken straight from the bus (needed when WAIT_STATES=0
   // enters RESP on the accepting edge); afterwards only the latched copy is used.
   logic              a_we;
   logic [2:0]        a_f3;
   logic [31:0]       a_addr, a_wdata;
   logic              a_fault;
   logic [DM_AW-1:0]  dm_idx;
   logic [31:0]       a_word;

   always_comb begin
      if (state_q == StIdle) begin
         a_we    = bus.we;
         a_f3    = bus.funct3;
         a_addr  = bus.addr;
         a_wdata = bus.wdata;
      end else begin
         a_we    = we_q;
         a_f3    = funct3_q;
         a_addr  = addr_q;
         a_wdata = wdata_q;
      end
      a_fault = calc_fault(a_we, a_f3, a_addr);
      dm_idx  = a_addr[DM_AW+1:2];
      a_word  = dm[dm_idx];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req) begin
               accept = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = StWait;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Store lane steering
   logic [3:0]  wmask;
   logic [31:0] wword;
   logic        dm_we;

   always_comb begin
      wmask = 4'b0000;
      wword = a_wdata;
      case (a_f3[1:0])
         2'b00: begin
            wmask = 4'b0001 << a_addr[1:0];
            wword = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            wmask = a_addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{a_wdata[15:0]}};
         end
         2'b10:   wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
      dm_we = enter_resp && a_we && !a_fault;
   end

   always_ff @(posedge clk) begin
      if (dm_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
               dm[dm_idx][8*b +: 8] <= wword[8*b +: 8];
            end
         end
      end
   end

   // Load extraction
   logic [31:0] shifted, load_val;
   logic [7:0]  lbyte;
   logic [15:0] lhalf;

   always_comb begin
      shifted = a_word >> {a_addr[1:0], 3'b000};
      lbyte   = shifted[7:0];
      lhalf   = a_addr[1] ? a_word[31:16] : a_word[15:0];
      case (a_f3)
         3'b000:  load_val = {{24{lbyte[7]}}, lbyte};
         3'b001:  load_val = {{16{lhalf[15]}}, lhalf};
         3'b100:  load_val = {24'd0, lbyte};
         3'b101:  load_val = {16'd0, lhalf};
         default: load_val = a_word;
      endcase
      rdata_d = (enter_resp && !a_we && !a_fault) ? load_val : rdata_q;
      fault_d = enter_resp ? a_fault : fault_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         fault_q  <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
         if (accept) begin
            we_q     <= bus.we;
            funct3_q <= bus.funct3;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
         end
      end
   end

   assign bus.ready = (state_q == StIdle);
   assign bus.done  = (state_q == StResp);
   assign bus.err   = (state_q == StResp) && fault_q;
   assign bus.rdata = rdata_q;

endmodule
